// File: rtl/wishbone_bus_splitter_n.sv
// Registered one-master-to-N-slave Wishbone classic splitter with address decode,
// one-cycle registered termination, decode-error and watchdog-timeout reporting.
//
// state | meaning
// IDLE  | waiting for a master cycle; decode happens here
// BUSY  | selected slave has cyc/stb asserted; watchdog running
// RESP  | master ack or err asserted for exactly one cycle
module wishbone_bus_splitter_n #(
    parameter int N_SLAVES   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS =
        {32'h3000_3000, 32'h3000_2000, 32'h3000_1000, 32'h3000_0000},
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] ADDR_MASKS = {4{32'hFFFF_F000}},
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          m_wb_adr,
    input  logic [DATA_WIDTH-1:0]          m_wb_dat_w,
    output logic [DATA_WIDTH-1:0]          m_wb_dat_r,
    input  logic                           m_wb_we,
    input  logic                           m_wb_cyc,
    input  logic                           m_wb_stb,
    input  logic [SEL_WIDTH-1:0]           m_wb_sel,
    output logic                           m_wb_ack,
    output logic                           m_wb_err,
    output logic [N_SLAVES*ADDR_WIDTH-1:0] s_wb_adr,
    output logic [N_SLAVES*DATA_WIDTH-1:0] s_wb_dat_w,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] s_wb_dat_r,
    output logic [N_SLAVES*SEL_WIDTH-1:0]  s_wb_sel,
    output logic [N_SLAVES-1:0]            s_wb_we,
    output logic [N_SLAVES-1:0]            s_wb_cyc,
    output logic [N_SLAVES-1:0]            s_wb_stb,
    input  logic [N_SLAVES-1:0]            s_wb_ack,
    input  logic [N_SLAVES-1:0]            s_wb_err,
    output logic                           busy,
    output logic                           decode_err,
    output logic                           timeout_err
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0]      sel_idx;
    logic                  cur_we;
    logic [WD_W-1:0]       wd_cnt;

    logic                  hit;
    logic [IDX_W-1:0]      hit_idx;
    logic                  sel_ack;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] sel_dat_r;
    logic                  wd_expired;

    logic do_load, do_drop, set_ack, set_err, set_dec, set_tmo, cap_rd, clr_rd;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((m_wb_adr & ADDR_MASKS[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                BASE_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_ack   = 1'b0;
        sel_err   = 1'b0;
        sel_dat_r = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_ack   = s_wb_ack[i];
                sel_err   = s_wb_err[i];
                sel_dat_r = s_wb_dat_r[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_W'(TIMEOUT_CYCLES));
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_drop   = 1'b0;
        set_ack   = 1'b0;
        set_err   = 1'b0;
        set_dec   = 1'b0;
        set_tmo   = 1'b0;
        cap_rd    = 1'b0;
        clr_rd    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (m_wb_cyc && m_wb_stb) begin
                    if (hit) begin
                        do_load   = 1'b1;
                        state_nxt = ST_BUSY;
                    end else begin
                        set_err   = 1'b1;
                        set_dec   = 1'b1;
                        clr_rd    = 1'b1;
                        state_nxt = ST_RESP;
                    end
                end
            end
            ST_BUSY: begin
                // A master abort outranks anything the slave says this cycle.
                if (!m_wb_cyc) begin
                    do_drop   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (sel_err) begin
                    do_drop   = 1'b1;
                    set_err   = 1'b1;
                    clr_rd    = 1'b1;
                    state_nxt = ST_RESP;
                end else if (sel_ack) begin
                    do_drop   = 1'b1;
                    set_ack   = 1'b1;
                    cap_rd    = !cur_we;
                    state_nxt = ST_RESP;
                end else if (wd_expired) begin
                    do_drop   = 1'b1;
                    set_err   = 1'b1;
                    set_tmo   = 1'b1;
                    clr_rd    = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_wb_ack    <= 1'b0;
            m_wb_err    <= 1'b0;
            m_wb_dat_r  <= '0;
            decode_err  <= 1'b0;
            timeout_err <= 1'b0;
            s_wb_adr    <= '0;
            s_wb_dat_w  <= '0;
            s_wb_sel    <= '0;
            s_wb_we     <= '0;
            s_wb_cyc    <= '0;
            s_wb_stb    <= '0;
            sel_idx     <= '0;
            cur_we      <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            m_wb_ack    <= set_ack;
            m_wb_err    <= set_err;
            decode_err  <= set_dec;
            timeout_err <= set_tmo;

            // Writes leave the last read data in place; any error wipes it.
            if (clr_rd) begin
                m_wb_dat_r <= '0;
            end else if (cap_rd) begin
                m_wb_dat_r <= sel_dat_r;
            end

            if (do_load) begin
                sel_idx <= hit_idx;
                cur_we  <= m_wb_we;
                wd_cnt  <= '0;
                for (int i = 0; i < N_SLAVES; i++) begin
                    if (hit_idx == IDX_W'(i)) begin
                        s_wb_adr[i*ADDR_WIDTH +: ADDR_WIDTH]   <= m_wb_adr;
                        s_wb_dat_w[i*DATA_WIDTH +: DATA_WIDTH] <= m_wb_dat_w;
                        s_wb_sel[i*SEL_WIDTH +: SEL_WIDTH]     <= m_wb_sel;
                        s_wb_we[i]  <= m_wb_we;
                        s_wb_cyc[i] <= 1'b1;
                        s_wb_stb[i] <= 1'b1;
                    end else begin
                        s_wb_adr[i*ADDR_WIDTH +: ADDR_WIDTH]   <= '0;
                        s_wb_dat_w[i*DATA_WIDTH +: DATA_WIDTH] <= '0;
                        s_wb_sel[i*SEL_WIDTH +: SEL_WIDTH]     <= '0;
                        s_wb_we[i]  <= 1'b0;
                        s_wb_cyc[i] <= 1'b0;
                        s_wb_stb[i] <= 1'b0;
                    end
                end
            end else begin
                if (do_drop) begin
                    s_wb_cyc <= '0;
                    s_wb_stb <= '0;
                end
                if (state == ST_BUSY && TIMEOUT_CYCLES != 0) begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end
            end
        end
    end

endmodule
